hcsr04_scheduler: RTL and testbench

- Round-robin measurement scheduler that shares one hc_sr04 ranging core between N_SENSORS ultrasonic sensors.
- Selects a sensor through an external echo/trig mux and launches a measurement on the core.
- Enforces an echo timeout, because the core has none and otherwise hangs in WAIT. Enforces an inter-measurement quiet gap against acoustic crosstalk.
- Keeps a per-sensor result bank that the application logic reads by index.

---
 rtl/hcsr04_pkg.sv | 27 ++
 rtl/rr_next_idx.sv | 30 +++
 rtl/hcsr04_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_hcsr04_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// Shared definitions for the hc_sr04 measurement scheduler and its consumers.
package hcsr04_pkg;

    localparam int unsigned DIST_W = 22;
    localparam logic [DIST_W-1:0] TIMEOUT_CODE = 22'h3FFFFF;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        BUSY,
        STORE,
        ABORT,
        GAP
    } state_t;

    typedef struct packed {
        logic [DIST_W-1:0] distance;
        logic              valid;
        logic              timeout;
    } bank_entry_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_next_idx.sv
// Combinational round-robin picker: first set mask bit strictly after last_idx,
// wrapping, so a lone set bit at last_idx is picked again.
module rr_next_idx #(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [SEL_W-1:0] last_idx,
    output logic [SEL_W-1:0] next_idx,
    output logic             none_set
);

    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        next_idx = last_idx;
        none_set = (mask == '0);
        cand     = '0;
        found    = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = SEL_W'((32'(last_idx) + k) % N);
            if (!found && mask[cand]) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hcsr04_scheduler.sv
// Round-robin scheduler sharing one hc_sr04 ranging core between several sensors,
// with echo timeout, inter-measurement quiet gap and a per-sensor result bank.
module hcsr04_scheduler
    import hcsr04_pkg::*;
#(
    parameter int unsigned N_SENSORS   = 4,
    parameter int unsigned TIMEOUT_CYC = 3_000_000,
    parameter int unsigned GAP_CYC     = 6_000_000,
    parameter int unsigned SEL_W       = $clog2(N_SENSORS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_SENSORS-1:0] sensor_mask,
    output logic [SEL_W-1:0]     sel,
    output logic                 core_measure,
    output logic                 core_rst,
    input  logic                 core_ready,
    input  logic [DIST_W-1:0]    core_distance,
    input  logic [SEL_W-1:0]     rd_idx,
    output logic [DIST_W-1:0]    rd_distance,
    output logic                 rd_valid,
    output logic                 rd_timeout,
    output logic                 done,
    output logic [SEL_W-1:0]     done_idx,
    output logic                 busy
);

    localparam int unsigned CNT_W  = $clog2(max_u(TIMEOUT_CYC, GAP_CYC) + 1);
    localparam int unsigned BANK_N = 1 << SEL_W;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             measure_q, measure_d;
    logic             core_rst_q, core_rst_d;
    logic             done_q, done_d;
    logic [SEL_W-1:0] done_idx_q, done_idx_d;
    logic             busy_q;
    bank_entry_t      bank_q [BANK_N];
    bank_entry_t      bank_d [BANK_N];

    logic [SEL_W-1:0] pick_idx;
    logic             none_set;

    rr_next_idx #(
        .N     (N_SENSORS),
        .SEL_W (SEL_W)
    ) u_rr_next_idx (
        .mask     (sensor_mask),
        .last_idx (last_q),
        .next_idx (pick_idx),
        .none_set (none_set)
    );

    // Saturating so a stuck state can never wrap back under the thresholds.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        cnt_d      = cnt_inc;
        measure_d  = 1'b0;
        core_rst_d = 1'b0;
        done_d     = 1'b0;
        done_idx_d = done_idx_q;
        bank_d     = bank_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en && (sensor_mask != '0)) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                cnt_d = '0;
                if (none_set) begin
                    state_d = IDLE;
                end else begin
                    sel_d     = pick_idx;
                    last_d    = pick_idx;
                    measure_d = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!core_ready) begin
                    state_d = BUSY;
                end else if (cnt_q >= TO_LAST) begin
                    state_d    = ABORT;
                    cnt_d      = '0;
                    core_rst_d = 1'b1;
                    done_d     = 1'b1;
                    done_idx_d = sel_q;
                end
            end
            BUSY: begin
                if (core_ready) begin
                    state_d    = STORE;
                    done_d     = 1'b1;
                    done_idx_d = sel_q;
                end else if (cnt_q >= TO_LAST) begin
                    state_d    = ABORT;
                    cnt_d      = '0;
                    core_rst_d = 1'b1;
                    done_d     = 1'b1;
                    done_idx_d = sel_q;
                end
            end
            STORE: begin
                bank_d[sel_q].distance = core_distance;
                bank_d[sel_q].valid    = 1'b1;
                bank_d[sel_q].timeout  = 1'b0;
                state_d = GAP;
                cnt_d   = '0;
            end
            ABORT: begin
                // Two cycles of core reset; the counter tells them apart.
                if (cnt_q == '0) begin
                    bank_d[sel_q].distance = TIMEOUT_CODE;
                    bank_d[sel_q].valid    = 1'b0;
                    bank_d[sel_q].timeout  = 1'b1;
                    core_rst_d = 1'b1;
                end else begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = en ? SELECT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            last_q     <= SEL_W'(N_SENSORS - 1);
            cnt_q      <= '0;
            measure_q  <= 1'b0;
            core_rst_q <= 1'b0;
            done_q     <= 1'b0;
            done_idx_q <= '0;
            busy_q     <= 1'b0;
            bank_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            measure_q  <= measure_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            done_idx_q <= done_idx_d;
            busy_q     <= (state_d != IDLE);
            bank_q     <= bank_d;
        end
    end

    assign sel          = sel_q;
    assign core_measure = measure_q;
    assign core_rst     = core_rst_q;
    assign done         = done_q;
    assign done_idx     = done_idx_q;
    assign busy         = busy_q;

    assign rd_distance = bank_q[rd_idx].distance;
    assign rd_valid    = bank_q[rd_idx].valid;
    assign rd_timeout  = bank_q[rd_idx].timeout;

endmodule

// File: tb/tb_hcsr04_scheduler.sv
// Bench for hcsr04_scheduler: behavioural ranging core with random echo delays,
// distances and masks, checked against a round-robin reference of the bank.
module tb_hcsr04_scheduler;
    import hcsr04_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned T  = 200;
    localparam int unsigned G  = 50;
    localparam int unsigned SW = 2;

    logic              clk, rst, en;
    logic [N-1:0]      sensor_mask;
    logic [SW-1:0]     sel, rd_idx, done_idx;
    logic              core_measure, core_rst, core_ready;
    logic              rd_valid, rd_timeout, done, busy;
    logic [DIST_W-1:0] core_distance, rd_distance;

    int n_cmp, n_bad, cyc;

    logic [DIST_W-1:0] dist_plan [N];
    logic              no_echo   [N];
    int                rise_cyc;
    bit                rise_valid;

    int launch_cyc, measure_cnt, double_meas, min_gap, max_gap;
    int rst_run, rst_pulses, rst_min, rst_max;
    bit prev_measure;

    int                ref_last;
    logic [DIST_W-1:0] ref_dist  [N];
    bit                ref_valid [N];
    bit                ref_tmo   [N];
    int                n_abort, n_launch, done_cyc;

    hcsr04_scheduler #(
        .N_SENSORS   (N),
        .TIMEOUT_CYC (T),
        .GAP_CYC     (G),
        .SEL_W       (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .sensor_mask   (sensor_mask),
        .sel           (sel),
        .core_measure  (core_measure),
        .core_rst      (core_rst),
        .core_ready    (core_ready),
        .core_distance (core_distance),
        .rd_idx        (rd_idx),
        .rd_distance   (rd_distance),
        .rd_valid      (rd_valid),
        .rd_timeout    (rd_timeout),
        .done          (done),
        .done_idx      (done_idx),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Ranging core: drops ready on a launch, echoes after a random delay unless told to hang.
    initial begin
        int  left;
        bit  active, hang;
        logic [DIST_W-1:0] pend;
        core_ready    = 1'b1;
        core_distance = '0;
        active = 1'b0; hang = 1'b0; left = 0; pend = '0;
        rise_cyc = 0; rise_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst || core_rst) begin
                core_ready = 1'b1;
                active     = 1'b0;
            end else if (active) begin
                if (!hang) begin
                    if (left == 0) begin
                        core_ready    = 1'b1;
                        core_distance = pend;
                        active        = 1'b0;
                        rise_cyc      = cyc;
                        rise_valid    = 1'b1;
                    end else begin
                        left--;
                    end
                end
            end else if (core_measure) begin
                core_ready = 1'b0;
                active     = 1'b1;
                hang       = no_echo[sel];
                left       = int'($urandom_range(3, 150));
                pend       = dist_plan[sel];
            end
        end
    end

    // Observes launches and core resets for the end-of-run checks.
    initial begin
        launch_cyc = 0; measure_cnt = 0; double_meas = 0; prev_measure = 1'b0;
        min_gap = 1000000; max_gap = 0;
        rst_run = 0; rst_pulses = 0; rst_min = 1000000; rst_max = 0;
        forever begin
            @(negedge clk);
            if (core_measure) begin
                if (prev_measure) double_meas++;
                measure_cnt++;
                if (rise_valid && rise_cyc > launch_cyc) begin
                    if (cyc - rise_cyc < min_gap) min_gap = cyc - rise_cyc;
                    if (cyc - rise_cyc > max_gap) max_gap = cyc - rise_cyc;
                end
                launch_cyc = cyc;
            end
            prev_measure = core_measure;
            if (core_rst) begin
                rst_run++;
            end else if (rst_run != 0) begin
                rst_pulses++;
                if (rst_run < rst_min) rst_min = rst_run;
                if (rst_run > rst_max) rst_max = rst_run;
                rst_run = 0;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int last, input logic [N-1:0] m);
        for (int k = 1; k <= int'(N); k++) begin
            if (m[(last + k) % int'(N)]) return (last + k) % int'(N);
        end
        return last;
    endfunction

    task automatic check_bank(input string tag, input int i);
        rd_idx = SW'(i);
        #1;
        chk({tag, " rd_distance"}, 32'(rd_distance), 32'(ref_dist[i]));
        chk({tag, " rd_valid"},    32'(rd_valid),    32'(ref_valid[i]));
        chk({tag, " rd_timeout"},  32'(rd_timeout),  32'(ref_tmo[i]));
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (done) begin
                ok       = 1'b1;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic run_attempt(input string tag);
        int   e;
        logic ok;
        e = pick(ref_last, sensor_mask);
        ref_last = e;
        n_launch++;
        wait_done(ok);
        chk({tag, " done seen"}, 32'(ok), 1);
        if (ok) begin
            chk({tag, " done_idx"}, 32'(done_idx), e);
            chk({tag, " sel"}, 32'(sel), e);
            if (no_echo[e]) begin
                ref_dist[e] = TIMEOUT_CODE; ref_valid[e] = 1'b0; ref_tmo[e] = 1'b1;
                n_abort++;
                chk({tag, " abort latency"}, done_cyc - launch_cyc, int'(T));
                chk({tag, " core_rst at abort"}, 32'(core_rst), 1);
            end else begin
                ref_dist[e] = dist_plan[e]; ref_valid[e] = 1'b1; ref_tmo[e] = 1'b0;
                chk({tag, " store latency"}, done_cyc - rise_cyc, 1);
            end
            @(negedge clk);
            check_bank(tag, e);
        end
    endtask

    initial begin
        logic ok;
        int   mc, fall;
        n_cmp = 0; n_bad = 0; n_abort = 0; n_launch = 0; done_cyc = 0;
        rst = 1'b0; en = 1'b0; sensor_mask = '0; rd_idx = '0;
        ref_last = int'(N) - 1;
        for (int i = 0; i < int'(N); i++) begin
            dist_plan[i] = DIST_W'(100 + i); no_echo[i] = 1'b0;
            ref_dist[i] = '0; ref_valid[i] = 1'b0; ref_tmo[i] = 1'b0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset sel", 32'(sel), 0);
        chk("reset core_measure", 32'(core_measure), 0);
        chk("reset core_rst", 32'(core_rst), 0);
        chk("reset done", 32'(done), 0);
        chk("reset done_idx", 32'(done_idx), 0);
        chk("reset busy", 32'(busy), 0);
        for (int i = 0; i < int'(N); i++) check_bank("reset bank", i);
        @(negedge clk);
        rst = 1'b1;

        // Empty mask keeps the scheduler idle
        en = 1'b1;
        repeat (40) @(negedge clk);
        chk("empty mask busy", 32'(busy), 0);
        chk("empty mask launches", measure_cnt, 0);

        // Full rotation 0,1,2,3,0
        sensor_mask = 4'b1111;
        for (int a = 0; a < 5; a++) run_attempt("rr1111");
        for (int i = 0; i < int'(N); i++) check_bank("rr1111 bank", i);

        // Asynchronous reset in the middle of a measurement
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (busy && !core_ready) ok = 1'b1;
        end
        chk("catch busy before reset", 32'(ok), 1);
        if (ok) n_launch++;
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < int'(N); i++) begin
            ref_dist[i] = '0; ref_valid[i] = 1'b0; ref_tmo[i] = 1'b0;
        end
        ref_last = int'(N) - 1;
        chk("async reset sel", 32'(sel), 0);
        chk("async reset busy", 32'(busy), 0);
        chk("async reset core_measure", 32'(core_measure), 0);
        chk("async reset core_rst", 32'(core_rst), 0);
        chk("async reset done", 32'(done), 0);
        for (int i = 0; i < int'(N); i++) check_bank("async reset bank", i);
        repeat (2) @(negedge clk);
        sensor_mask = 4'b0101;
        en  = 1'b1;
        rst = 1'b1;

        // Sparse mask 0,2,0,2
        for (int a = 0; a < 4; a++) run_attempt("rr0101");
        check_bank("rr0101 unvisited", 1);
        check_bank("rr0101 unvisited", 3);

        // Sensor 2 never echoes
        sensor_mask = 4'b1111;
        no_echo[2]  = 1'b1;
        for (int a = 0; a < 5; a++) run_attempt("timeout");
        no_echo[2] = 1'b0;

        // Random masks, distances and hung sensors
        for (int a = 0; a < 12; a++) begin
            sensor_mask = 4'($urandom_range(1, 15));
            for (int j = 0; j < int'(N); j++) begin
                no_echo[j]   = ($urandom_range(0, 4) == 0);
                dist_plan[j] = DIST_W'($urandom);
            end
            run_attempt("random");
        end

        // Enable dropped while sensor 1 is measuring
        for (int j = 0; j < int'(N); j++) no_echo[j] = 1'b0;
        sensor_mask  = 4'b0010;
        dist_plan[1] = 22'h2A5A5;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (busy && !core_ready && sel == 2'd1) ok = 1'b1;
        end
        chk("catch sensor 1 busy", 32'(ok), 1);
        en = 1'b0;
        run_attempt("en drop");
        ok = 1'b0; fall = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok   = 1'b1;
                fall = cyc;
            end
        end
        chk("en drop busy falls", 32'(ok), 1);
        chk("en drop idle latency", fall - done_cyc, int'(G) + 1);
        mc = measure_cnt;
        repeat (100) @(negedge clk);
        chk("en drop no relaunch", measure_cnt, mc);
        chk("en drop busy", 32'(busy), 0);

        // Enabled but nothing in the mask
        sensor_mask = 4'b0000;
        en = 1'b1;
        repeat (60) @(negedge clk);
        chk("zero mask busy", 32'(busy), 0);
        chk("zero mask launches", measure_cnt, mc);

        for (int i = 0; i < int'(N); i++) check_bank("final bank", i);
        chk("single-cycle launch pulses", double_meas, 0);
        chk("min ready-to-launch gap", min_gap, int'(G) + 3);
        chk("max ready-to-launch gap", max_gap, int'(G) + 3);
        chk("core_rst pulse count", rst_pulses, n_abort);
        chk("core_rst min length", rst_min, 2);
        chk("core_rst max length", rst_max, 2);
        chk("launch count", measure_cnt, n_launch);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
